bg_fill_writer: RTL and testbench

Rectangle-fill writer for the 5-bit background frame memory (153,600 entries, 640 × 240 layout, address = y·640 + x). It is the write-side counterpart of the background read path. It accepts a fill command (origin, size, palette index), clips it to the frame, and issues one memory write per granted cycle. A start/busy/done handshake connects it to game logic, and a grant input lets the pixel reader win arbitration.

---
 rtl/bg_fill_writer.sv | 157 +++++++++++++++
 tb/tb_bg_fill_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bg_fill_writer.sv
// Rectangle-fill writer for the 640x240 background frame memory.
// Clips a fill command to the frame and issues one write per granted cycle.
module bg_fill_writer #(
  parameter int unsigned FRAME_W = 640,
  parameter int unsigned FRAME_H = 240
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [8:0]  y0,
  input  logic [9:0]  w,
  input  logic [8:0]  h,
  input  logic [4:0]  color,
  input  logic        bg_wr_grant,
  output logic        busy,
  output logic        done,
  output logic        bg_we,
  output logic [18:0] bg_write_address,
  output logic [4:0]  bg_data_in
);

  localparam logic [10:0] FW11 = 11'(FRAME_W);
  localparam logic [9:0]  FW10 = 10'(FRAME_W);
  localparam logic [18:0] FW19 = 19'(FRAME_W);
  localparam logic [9:0]  FH10 = 10'(FRAME_H);
  localparam logic [8:0]  FH9  = 9'(FRAME_H);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  x0_q, x0_d;
  logic [8:0]  y0_q, y0_d;
  logic [9:0]  w_q, w_d;
  logic [8:0]  h_q, h_d;
  logic [4:0]  color_q, color_d;
  logic [9:0]  xlast_q, xlast_d;
  logic [8:0]  ylast_q, ylast_d;
  logic [9:0]  cx_q, cx_d;
  logic [8:0]  cy_q, cy_d;
  logic [18:0] row_base_q, row_base_d;
  logic [18:0] addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [10:0] xsum, xend;
  logic [9:0]  ysum, yend;

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    xlast_d    = xlast_q;
    ylast_d    = ylast_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    xsum       = {1'b0, x0_q} + {1'b0, w_q};
    ysum       = {1'b0, y0_q} + {1'b0, h_q};
    xend       = (xsum > FW11) ? FW11 : xsum;
    yend       = (ysum > FH10) ? FH10 : ysum;

    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          w_d     = w;
          h_d     = h;
          color_d = color;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // Inclusive last column/row so FILL compares against a register directly.
        xlast_d    = 10'(xend - 11'd1);
        ylast_d    = 9'(yend - 10'd1);
        row_base_d = 19'(y0_q) * FW19;
        addr_d     = row_base_d + 19'(x0_q);
        cx_d       = x0_q;
        cy_d       = y0_q;
        if (w_q == '0 || h_q == '0 || x0_q >= FW10 || y0_q >= FH9)
          state_d = DONE;
        else
          state_d = FILL;
      end
      FILL: begin
        if (bg_wr_grant) begin
          if (cx_q == xlast_q) begin
            if (cy_q == ylast_q) begin
              state_d = DONE;
            end else begin
              cx_d       = x0_q;
              cy_d       = cy_q + 9'd1;
              row_base_d = row_base_q + FW19;
              addr_d     = row_base_q + FW19 + 19'(x0_q);
            end
          end else begin
            cx_d   = cx_q + 10'd1;
            addr_d = addr_q + 19'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      xlast_q    <= '0;
      ylast_q    <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      xlast_q    <= xlast_d;
      ylast_q    <= ylast_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Gated by Reset so no write lands on the edge that aborts a fill.
  assign bg_we            = (state_q == FILL) && bg_wr_grant && !Reset;
  assign busy             = busy_q;
  assign done             = done_q;
  assign bg_write_address = addr_q;
  assign bg_data_in       = color_q;

endmodule

// File: tb/tb_bg_fill_writer.sv
// Scoreboard bench for bg_fill_writer: a pixel-list model feeds expected
// writes and done cycles to queues; a negedge monitor pops and compares.
module tb_bg_fill_writer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  x0 = '0;
  logic [8:0]  y0 = '0;
  logic [9:0]  w = '0;
  logic [8:0]  h = '0;
  logic [4:0]  color = '0;
  logic        bg_wr_grant = 1'b1;
  logic        busy, done, bg_we;
  logic [18:0] bg_write_address;
  logic [4:0]  bg_data_in;

  bg_fill_writer #(.FRAME_W(640), .FRAME_H(240)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
    .color(color), .bg_wr_grant(bg_wr_grant), .busy(busy), .done(done),
    .bg_we(bg_we), .bg_write_address(bg_write_address), .bg_data_in(bg_data_in)
  );

  always #5 Clk = ~Clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  done_exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gmode = 0;          // 0: grant high, 1: random, 2: grant = cycle parity
  int cur_setup = 0;
  int last_wr_cyc = 0;
  bit prev_done = 0;
  bit stall_pending = 0;
  int stall_addr = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  always @(posedge Clk) begin
    #2;
    case (gmode)
      0: bg_wr_grant = 1'b1;
      1: bg_wr_grant = 1'($urandom % 2);
      default: bg_wr_grant = 1'(cyc % 2);
    endcase
  end

  // Monitor: compares every write and done pulse against the queues.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (stall_pending) chk("stall_addr_hold", int'(bg_write_address), stall_addr);
      stall_pending = 0;
      if (busy && !done && cyc > cur_setup && !bg_wr_grant) begin
        stall_pending = 1;
        stall_addr = int'(bg_write_address);
      end
      if (bg_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", int'(bg_write_address), -1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", int'(bg_write_address), e.addr);
          chk("write_data", int'(bg_data_in), e.data);
        end
        last_wr_cyc = cyc;
      end
      if (done) begin
        chk("busy_with_done", int'(busy), 1);
        if (done_exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          int d;
          d = done_exp_q.pop_front();
          if (d >= 0) chk("done_cycle", cyc, d);
          else        chk("done_after_last_write", cyc, last_wr_cyc + 1);
          chk("writes_left_at_done", exp_q.size(), 0);
        end
      end
      if (prev_done) chk("busy_after_done", int'(busy), 0);
      prev_done = done;
    end else begin
      prev_done = 0;
      stall_pending = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge Clk); #2;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", n);
    end
  endtask

  // keep: number of expected writes to enqueue (-1 = all); push_done: expect a done pulse.
  task automatic run_cmd(input int x, input int y, input int ww, input int hh,
                         input int c, input int keep, input bit push_done);
    int c0, xend, yend, n, k, pushed;
    wait_idle();
    x0 = 10'(x); y0 = 9'(y); w = 10'(ww); h = 9'(hh); color = 5'(c);
    start = 1'b1;
    @(posedge Clk); #1;
    c0 = cyc;
    cur_setup = c0;
    xend = (x + ww > 640) ? 640 : x + ww;
    yend = (y + hh > 240) ? 240 : y + hh;
    n = 0;
    pushed = 0;
    for (int yy = y; yy < yend; yy++)
      for (int xx = x; xx < xend; xx++) begin
        n++;
        if (keep < 0 || pushed < keep) begin
          wr_t e;
          e.addr = yy * 640 + xx;
          e.data = c;
          exp_q.push_back(e);
          pushed++;
        end
      end
    if (push_done) begin
      if (gmode == 1 && n > 0) begin
        done_exp_q.push_back(-1);
      end else begin
        k = c0 + 1;
        for (int m = 0; m < n; k++)
          if (gmode == 0 || (k % 2) == 1) m++;
        done_exp_q.push_back(k);
      end
    end
    #1;
    start = 1'b0;
    color = 5'($urandom);
    x0 = 10'($urandom);
    y0 = 9'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b0;
    @(negedge Clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_we", int'(bg_we), 0);
    chk("reset_addr", int'(bg_write_address), 0);
    chk("reset_data", int'(bg_data_in), 0);
    @(posedge Clk); #2;

    gmode = 0;
    run_cmd(10, 5, 4, 2, 7, -1, 1);       // basic
    run_cmd(638, 239, 5, 3, 31, -1, 1);   // clipped to 2 pixels
    run_cmd(20, 20, 0, 3, 4, -1, 1);      // w = 0
    run_cmd(700, 10, 3, 3, 4, -1, 1);     // x0 off frame
    run_cmd(5, 240, 3, 3, 4, -1, 1);      // y0 off frame
    wait_idle();

    gmode = 2;
    run_cmd(0, 0, 3, 1, 9, -1, 1);        // stalled fill
    wait_idle();
    gmode = 0;

    // start pulsed during SETUP and FILL must be ignored
    run_cmd(100, 50, 3, 2, 12, -1, 1);
    x0 = 10'd300; y0 = 9'd100; w = 10'd5; h = 9'd5; color = 5'd1;
    start = 1'b1;
    @(posedge Clk); #2;
    @(posedge Clk); #2;
    start = 1'b0;
    wait_idle();

    // reset after two writes of a 4x2 fill
    run_cmd(0, 0, 4, 2, 21, 2, 0);
    @(posedge Clk); #2;
    @(posedge Clk); #2;
    @(posedge Clk); #2;
    Reset = 1'b1;
    @(posedge Clk); #2;
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_we", int'(bg_we), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_writes_left", exp_q.size(), 0);
    @(posedge Clk); #2;
    run_cmd(0, 0, 1, 1, 3, -1, 1);
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      gmode = (i % 3 == 0) ? 0 : 1;
      run_cmd(int'($urandom_range(0, 700)), int'($urandom_range(0, 250)),
              int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 31)), -1, 1);
      wait_idle();
    end
    gmode = 0;

    repeat (4) @(posedge Clk);
    #2;
    chk("leftover_writes", exp_q.size(), 0);
    chk("leftover_done", done_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
